iters_frame_buffer: RTL and testbench

ITERS_FRAME_BUFFER -- requirements
Module: iters_frame_buffer

---
 rtl/iters_frame_buffer.sv | 194 +++++++++++++++++++
 tb/tb_iters_frame_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iters_frame_buffer.sv
// iters_frame_buffer
//   Double-buffered frame store of per-pixel iteration counts. The writer side
//   accepts batches of FMA_COUNT counts and writes them, one per cycle, to
//   consecutive addresses. The HDMI side reads the other buffer and maps each
//   count to an RGB colour.
//
// Ports
//   sys_clk_in, rst_n_in         clock, async active-low reset
//   iters_valid_in/ready_out     batch handshake
//   iters_in                     FMA_COUNT packed counts, element 0 in the MSBs
//   addr_in                      frame address of element 0 (x*HEIGHT + y)
//   swap_req_in                  request a buffer swap
//   swap_done_out                one-cycle pulse in the cycle the swap executes
//   write_buf_out                index of the buffer currently written
//   x_draw_in, y_draw_in         pixel being drawn
//   red_out/green_out/blue_out   colour, 2 cycles after x/y
module iters_frame_buffer #(
  parameter int FMA_COUNT  = 2,
  parameter int ITERS_BITS = 4,
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 320,
  parameter int COLOR_MODE = 0
) (
  input  logic                                sys_clk_in,
  input  logic                                rst_n_in,
  input  logic                                iters_valid_in,
  output logic                                iters_ready_out,
  input  logic [FMA_COUNT*ITERS_BITS-1:0]     iters_in,
  input  logic [$clog2(WIDTH*HEIGHT)-1:0]     addr_in,
  input  logic                                swap_req_in,
  output logic                                swap_done_out,
  output logic                                write_buf_out,
  input  logic [10:0]                         x_draw_in,
  input  logic [9:0]                          y_draw_in,
  output logic [7:0]                          red_out,
  output logic [7:0]                          green_out,
  output logic [7:0]                          blue_out
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;
  localparam int DW    = FMA_COUNT * ITERS_BITS;
  localparam logic [IW-1:0] LAST = IW'(FMA_COUNT - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q;
  logic [DW-1:0]       iters_q;
  logic [AW-1:0]       base_q;
  logic                swap_pending_q;
  logic                last_beat, hs, swap_exec;

  // ---------------- write side ----------------
  assign last_beat       = (state_q == WRITE) && (idx_q == LAST);
  assign iters_ready_out = !swap_pending_q && ((state_q == IDLE) || last_beat);
  assign hs              = iters_valid_in && iters_ready_out;
  // While a swap is pending ready is low, so no batch can start underneath it;
  // the swap lands either in an idle cycle or alongside the final write.
  assign swap_exec       = swap_pending_q && (((state_q == IDLE) && !hs) || last_beat);
  assign swap_done_out   = swap_exec;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = WRITE;
      WRITE:   if (last_beat && !hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      iters_q        <= '0;
      base_q         <= '0;
      swap_pending_q <= 1'b0;
      write_buf_out  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        iters_q <= iters_in;
        base_q  <= addr_in;
        idx_q   <= '0;
      end else if (last_beat) begin
        idx_q   <= '0;
      end else if (state_q == WRITE) begin
        idx_q   <= idx_q + 1'b1;
      end
      // A request arriving in the executing cycle is folded into that swap.
      swap_pending_q <= !swap_exec && (swap_pending_q || swap_req_in);
      if (swap_exec) write_buf_out <= !write_buf_out;
    end
  end

  logic [ITERS_BITS-1:0] wr_data;
  logic [AW:0]           wr_addr;
  logic                  wr_en;

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < FMA_COUNT; i++)
      if (idx_q == IW'(i)) wr_data = iters_q[(FMA_COUNT-1-i)*ITERS_BITS +: ITERS_BITS];
  end

  // One extra address bit so base+idx past the frame end is caught, not wrapped.
  assign wr_addr = {1'b0, base_q} + (AW+1)'(idx_q);
  assign wr_en   = (state_q == WRITE) && (wr_addr < (AW+1)'(DEPTH));

  logic [ITERS_BITS-1:0] mem0 [DEPTH];
  logic [ITERS_BITS-1:0] mem1 [DEPTH];

  // Frame contents survive reset.
  always_ff @(posedge sys_clk_in) begin
    if (wr_en) begin
      if (write_buf_out) mem1[wr_addr[AW-1:0]] <= wr_data;
      else               mem0[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // ---------------- read side ----------------
  logic          rd_inb;
  logic [AW-1:0] rd_addr;

  assign rd_inb  = (32'(x_draw_in) < WIDTH) && (32'(y_draw_in) < HEIGHT);
  assign rd_addr = rd_inb ? AW'(32'(x_draw_in) * HEIGHT + 32'(y_draw_in)) : '0;

  logic [ITERS_BITS-1:0] s1_iters;
  logic                  s1_inb;

  // Stage 1 captures the data itself, so a swap after this point cannot
  // change a pixel already in flight.
  always_ff @(posedge sys_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_iters <= '0;
      s1_inb   <= 1'b0;
    end else begin
      s1_iters <= write_buf_out ? mem0[rd_addr] : mem1[rd_addr];
      s1_inb   <= rd_inb;
    end
  end

  function automatic logic [23:0] palette(input logic [3:0] i);
    case (i)
      4'd0:    palette = {8'd66,  8'd30,  8'd15 };
      4'd1:    palette = {8'd25,  8'd7,   8'd26 };
      4'd2:    palette = {8'd9,   8'd1,   8'd47 };
      4'd3:    palette = {8'd4,   8'd4,   8'd73 };
      4'd4:    palette = {8'd0,   8'd7,   8'd100};
      4'd5:    palette = {8'd12,  8'd44,  8'd138};
      4'd6:    palette = {8'd24,  8'd82,  8'd177};
      4'd7:    palette = {8'd57,  8'd125, 8'd209};
      4'd8:    palette = {8'd134, 8'd181, 8'd229};
      4'd9:    palette = {8'd211, 8'd236, 8'd248};
      4'd10:   palette = {8'd241, 8'd233, 8'd191};
      4'd11:   palette = {8'd248, 8'd201, 8'd95 };
      4'd12:   palette = {8'd255, 8'd170, 8'd0  };
      4'd13:   palette = {8'd204, 8'd128, 8'd0  };
      4'd14:   palette = {8'd153, 8'd87,  8'd0  };
      default: palette = 24'd0;
    endcase
  endfunction

  // Count bits repeated MSB-first until 8 bits are filled.
  function automatic logic [7:0] gray(input logic [ITERS_BITS-1:0] v);
    logic [7:0] g;
    for (int i = 0; i < 8; i++) g[7-i] = v[ITERS_BITS-1-(i % ITERS_BITS)];
    return g;
  endfunction

  logic [23:0] col;

  // All-ones means "never escaped" and is drawn black in both modes.
  always_comb begin
    col = '0;
    if (s1_inb && (s1_iters != '1)) begin
      if (COLOR_MODE == 0) col = palette(s1_iters[ITERS_BITS-1 -: 4]);
      else                 col = {3{gray(s1_iters)}};
    end
  end

  always_ff @(posedge sys_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else begin
      {red_out, green_out, blue_out} <= col;
    end
  end

endmodule

// File: tb/tb_iters_frame_buffer.sv
// Bench for iters_frame_buffer: two instances share every input, one in
// palette mode and one in grayscale mode. A reference model keeps both frame
// buffers as associative arrays and derives colours from the colour rules.
module tb_iters_frame_buffer;
  localparam int FC = 2;
  localparam int IB = 4;
  localparam int W  = 320;
  localparam int H  = 320;
  localparam int D  = W * H;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0, rst_n = 1'b0, valid = 1'b0, swap_req = 1'b0;
  logic [7:0]    iters = '0;
  logic [AW-1:0] addr = '0;
  logic [10:0]   x = '0;
  logic [9:0]    y = '0;
  logic          ready, done, wbuf, ready_g, done_g, wbuf_g;
  logic [7:0]    r, g, b, r_g, g_g, b_g;

  always #5 clk = ~clk;

  iters_frame_buffer #(.FMA_COUNT(FC), .ITERS_BITS(IB), .WIDTH(W), .HEIGHT(H), .COLOR_MODE(0)) dut (
    .sys_clk_in(clk), .rst_n_in(rst_n), .iters_valid_in(valid), .iters_ready_out(ready),
    .iters_in(iters), .addr_in(addr), .swap_req_in(swap_req), .swap_done_out(done),
    .write_buf_out(wbuf), .x_draw_in(x), .y_draw_in(y),
    .red_out(r), .green_out(g), .blue_out(b));

  iters_frame_buffer #(.FMA_COUNT(FC), .ITERS_BITS(IB), .WIDTH(W), .HEIGHT(H), .COLOR_MODE(1)) dut_g (
    .sys_clk_in(clk), .rst_n_in(rst_n), .iters_valid_in(valid), .iters_ready_out(ready_g),
    .iters_in(iters), .addr_in(addr), .swap_req_in(swap_req), .swap_done_out(done_g),
    .write_buf_out(wbuf_g), .x_draw_in(x), .y_draw_in(y),
    .red_out(r_g), .green_out(g_g), .blue_out(b_g));

  int n_cmp = 0, n_err = 0;
  int mb0[int];
  int mb1[int];
  bit mwb = 1'b0;
  int wq[$];
  int pal_r [16] = '{66,25,9,4,0,12,24,57,134,211,241,248,255,204,153,0};
  int pal_g [16] = '{30,7,1,4,7,44,82,125,181,236,233,201,170,128,87,0};
  int pal_b [16] = '{15,26,47,73,100,138,177,209,229,248,191,95,0,0,0,0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic void mset(bit bs, int a, int v);
    if (a >= D) return;
    if (bs) mb1[a] = v; else mb0[a] = v;
  endfunction

  function automatic int mget(bit bs, int a);
    if (bs) return mb1.exists(a) ? mb1[a] : -1;
    return mb0.exists(a) ? mb0[a] : -1;
  endfunction

  function automatic logic [23:0] ref_col(int cnt, bit mode);
    if (cnt < 0) return 24'hffffff;
    if (cnt == 15) return 24'd0;
    if (mode) return {3{8'(cnt * 17)}};
    return {8'(pal_r[cnt]), 8'(pal_g[cnt]), 8'(pal_b[cnt])};
  endfunction

  // {palette colour, grayscale colour} as visible 2 cycles after x/y.
  function automatic logic [47:0] exp_px(int xx, int yy);
    if (xx >= W || yy >= H) return 48'd0;
    return {ref_col(mget(!mwb, xx*H + yy), 1'b0), ref_col(mget(!mwb, xx*H + yy), 1'b1)};
  endfunction

  task automatic check_px(input string tag, input logic [47:0] e);
    chk(tag, 32'({r, g, b}), 32'(e[47:24]));
    chk({tag, "_gray"}, 32'({r_g, g_g, b_g}), 32'(e[23:0]));
  endtask

  task automatic send(input logic [7:0] d, input int a, output int waits);
    valid = 1'b1; iters = d; addr = AW'(a); waits = 0;
    while (!ready && waits < 20) begin tick; waits++; end
    chk("send_ready", 32'(ready), 32'd1);
    tick;
    valid = 1'b0;
    for (int i = 0; i < FC; i++) begin
      mset(mwb, a + i, (int'(d) >> ((FC-1-i)*IB)) & 15);
      if (a + i < D) wq.push_back(a + i);
    end
  endtask

  task automatic do_swap(input string tag);
    int n = 0;
    swap_req = 1'b1; tick; swap_req = 1'b0;
    while (!done && n < 20) begin tick; n++; end
    chk({tag, "_done"}, 32'(done), 32'd1);
    tick;
    mwb = !mwb;
    chk({tag, "_wbuf"}, 32'(wbuf), 32'(mwb));
    chk({tag, "_pulse_end"}, 32'(done), 32'd0);
  endtask

  task automatic read1(input string tag, input int xx, input int yy);
    logic [47:0] e;
    x = 11'(xx); y = 10'(yy); e = exp_px(xx, yy);
    tick; tick;
    check_px(tag, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [47:0] e, eq[$];
    int a, px, qx;

    // reset
    repeat (3) tick;
    rst_n = 1'b1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wbuf", 32'(wbuf), 32'd0);
    check_px("rst_col", 48'd0);

    // batch A3 @100, swap, exact 2-cycle read latency
    send(8'hA3, 100, w);
    do_swap("swap1");
    x = 11'd320; y = 10'd5; repeat (3) tick;
    check_px("oob_x320", 48'd0);
    x = 11'd0; y = 10'd100; e = exp_px(0, 100);
    tick;
    check_px("lat_1cyc", 48'd0);
    tick;
    check_px("px_100", e);
    read1("px_101", 0, 101);

    // swap requested during the first WRITE cycle, re-requested while executing
    valid = 1'b1; iters = 8'h12; addr = AW'(200);
    chk("r18_rdy_idle", 32'(ready), 32'd1);
    tick;
    valid = 1'b0;
    mset(mwb, 200, 1); mset(mwb, 201, 2);
    swap_req = 1'b1;
    chk("r18_rdy_w0", 32'(ready), 32'd0);
    chk("r18_done_w0", 32'(done), 32'd0);
    tick;
    chk("r18_rdy_w1", 32'(ready), 32'd0);
    chk("r18_done_w1", 32'(done), 32'd1);
    tick;
    swap_req = 1'b0;
    mwb = !mwb;
    chk("r18_wbuf", 32'(wbuf), 32'(mwb));
    for (int i = 0; i < 3; i++) begin
      chk("r18_no_extra_done", 32'(done), 32'd0);
      tick;
      chk("r18_no_extra_wbuf", 32'(wbuf), 32'(mwb));
    end
    read1("px_200", 0, 200);
    read1("px_201", 0, 201);

    // all-ones count draws black
    send(8'hF0, 300, w);
    do_swap("swap_f0");
    read1("px_cnt15", 0, 300);
    read1("px_cnt0", 0, 301);

    // last frame address, overflow element suppressed, address 0 untouched
    send(8'h78, 0, w);
    send(8'h21, D - 1, w);
    chk("b2b_wait", 32'(w), 32'(FC - 1));
    do_swap("swap_end");
    read1("px_last", W - 1, H - 1);
    read1("px_addr0", 0, 0);
    read1("px_addr1_cnt8", 0, 1);

    // reset one cycle after handshake abandons the second write
    send(8'hCD, 0, w);
    tick; tick;
    valid = 1'b1; iters = 8'h56; addr = '0;
    tick;
    valid = 1'b0;
    tick;
    rst_n = 1'b0;
    mset(mwb, 0, 5);
    mwb = 1'b0;
    #1;
    chk("r21_wbuf_rst", 32'(wbuf), 32'd0);
    check_px("r21_col_rst", 48'd0);
    tick; tick;
    rst_n = 1'b1;
    chk("r21_ready", 32'(ready), 32'd1);
    chk("r21_wbuf", 32'(wbuf), 32'd0);
    do_swap("swap_r21");
    read1("r21_addr0", 0, 0);
    read1("r21_addr1", 0, 1);

    // randomized back-to-back batches, then pipelined random reads
    wq.delete();
    for (int k = 0; k < 24; k++) begin
      a = ($urandom_range(0, 7) == 0) ? D - 1 - int'($urandom_range(0, 1))
                                     : int'($urandom_range(0, D - 1));
      send(8'($urandom_range(0, 255)), a, w);
      if (k > 0) chk("rnd_thru", 32'(w), 32'(FC - 1));
    end
    do_swap("swap_rnd");
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        x = 11'($urandom_range(0, 1) ? $urandom_range(W, 2047) : $urandom_range(0, W - 1));
        y = (x >= 11'(W)) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(H, 1023));
      end else begin
        a = wq[$urandom_range(0, wq.size() - 1)];
        x = 11'(a / H); y = 10'(a % H);
      end
      eq.push_back(exp_px(int'(x), int'(y)));
      tick;
      if (eq.size() == 2) check_px("rnd_px", eq.pop_front());
    end
    tick;
    check_px("rnd_px", eq.pop_front());

    // swap lands between the two read stages
    px = wq[0];
    qx = 100;
    swap_req = 1'b1; tick; swap_req = 1'b0;
    chk("mid_done", 32'(done), 32'd1);
    x = 11'(px / H); y = 10'(px % H); e = exp_px(px / H, px % H);
    tick;
    mwb = !mwb;
    chk("mid_wbuf", 32'(wbuf), 32'(mwb));
    x = 11'(0); y = 10'(qx); eq.push_back(exp_px(0, qx));
    tick;
    check_px("mid_inflight", e);
    tick;
    check_px("mid_newbuf", eq.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
